cosine_job_ctrl: RTL and testbench
==================================

Name: cosine_job_ctrl

Overview:
- Host-side initiator for the cosine-similarity micro-coded engine.
- Accepts (A, B) packed 4x8-bit vector pairs through a valid/ready job queue.
- Per job: re-arms the engine, pulses start, holds operands stable, waits for done (with timeout), and returns the 16-bit result on a valid/ready result port.
- Sits between the bus/register front-end and the engine.

Parameters:
- DEPTH, 4, job FIFO entries (power of two, >=2).
- TIMEOUT, 40, max cycles in RUN before a job is aborted (engine nominally needs ~26).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  job FIFO not full
- job_a  in  32  vector A, 4x8-bit, byte 0 = element 0
- job_b  in  32  vector B, same packing
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  16  cosine result; quotient in [3:0]
- res_timeout  out  1  result is a timeout abort
- eng_rst_n  out  1  engine re-arm, active-low
- eng_start  out  1  engine start pulse
- eng_a_vec  out  32  engine operand A
- eng_b_vec  out  32  engine operand B
- eng_done  in  1  engine done (sticky until engine reset)
- eng_result  in  16  engine cosine_similarity
- busy  out  1  state != IDLE or FIFO non-empty
- jobs_done  out  8  completed result handshakes, wraps 255->0

Behaviour:
- Reset values: job_ready=1, res_valid=0, res_data=0, res_timeout=0, eng_rst_n=0, eng_start=0, eng_a_vec=0, eng_b_vec=0, busy=0, jobs_done=0, FIFO empty, state IDLE, timeout counter 0.
- Reset mid-operation discards queued jobs, the in-flight job and any pending result.
- Job FIFO:
  - Push on job_valid & job_ready.
  - job_ready = !full, where full is taken from the registered count.
  - No push-through when full: a push offered while full waits, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
- All eng_* and res_* outputs are registered.
- FSM:
  - IDLE:
    - eng_rst_n=1.
    - If FIFO non-empty at the clock edge: pop, load eng_a_vec/eng_b_vec, go to ARM.
    - A job pushed in the same cycle is not popped until the next cycle.
  - ARM (1 cycle): eng_rst_n=0, which clears the engine's sticky done. Go to LAUNCH.
  - LAUNCH (1 cycle): eng_rst_n=1, eng_start=1. Clear the timeout counter. Go to RUN.
  - RUN:
    - eng_start=0; counter increments each cycle.
    - eng_done is sampled only in RUN and ignored in all other states.
    - If eng_done=1: res_data<=eng_result, res_timeout<=0, go to RESULT.
    - Else if counter==TIMEOUT-1: res_data<=0, res_timeout<=1, go to RESULT.
    - If done and timeout occur in the same cycle, done wins.
  - RESULT:
    - res_valid=1; res_data and res_timeout held stable.
    - On res_ready: res_valid<=0, jobs_done<=jobs_done+1, go to IDLE.
- eng_a_vec/eng_b_vec are stable from ARM through RESULT and change only on the next pop.
- Minimum timeline: pop edge t; eng_rst_n low during t+1; eng_start high during t+2; RUN from t+3.
- Job throughput is one in flight. The FIFO keeps accepting while the engine runs, so up to DEPTH+1 jobs are held in total.
- Counter width is $clog2(TIMEOUT)+1. TIMEOUT=1 aborts on the first RUN cycle.

Test Plan:
- Single job, A=32'h04030201, B=32'h08070605, engine model asserts done with result 16'h0007 26 cycles after start -> eng_rst_n low exactly 1 cycle, eng_start high exactly 1 cycle, res_data=16'h0007, res_timeout=0, jobs_done=1, busy falls after the handshake.
- Engine stalled, 6 jobs offered back-to-back, DEPTH=4:
  - 5 accepted (1 in engine, 4 queued); job_ready=0 while the 6th waits.
  - 6th accepted the cycle after the next pop.
  - Results return in FIFO order.
- eng_done never asserted, TIMEOUT=40 -> res_valid exactly 40 cycles after RUN entry with res_data=0, res_timeout=1; the next job proceeds normally.
- res_ready held low 10 cycles with 2 jobs queued -> res_valid/res_data stable, no eng_start; next ARM happens 2 cycles after the handshake edge.
- eng_done asserted on cycle TIMEOUT-1 of RUN -> real result captured, res_timeout=0.
- reset deasserted then asserted mid-RUN with 3 jobs queued -> all outputs at reset values; after release, FIFO empty, job_ready=1, jobs_done=0, no spurious res_valid.

Source files
------------

// File: rtl/cosine_job_ctrl.sv
// Host-side job controller for the cosine-similarity engine.
// Queues operand pairs, sequences the engine per job and returns results.
`timescale 1ns/1ps
module cosine_job_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_a,
  input  logic [31:0] job_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_timeout,
  output logic        eng_rst_n,
  output logic        eng_start,
  output logic [31:0] eng_a_vec,
  output logic [31:0] eng_b_vec,
  input  logic        eng_done,
  input  logic [15:0] eng_result,
  output logic        busy,
  output logic [7:0]  jobs_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TMAX     = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    RUN,
    RESULT
  } state_t;

  state_t state, state_nx;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [CW-1:0] tcnt;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE) || !empty;

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {job_a, job_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!empty) state_nx = ARM;
      ARM:     state_nx = LAUNCH;
      LAUNCH:  state_nx = RUN;
      RUN:     if (eng_done || tcnt == TMAX) state_nx = RESULT;
      RESULT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Engine strobes follow the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_rst_n <= 1'b0;
      eng_start <= 1'b0;
      eng_a_vec <= '0;
      eng_b_vec <= '0;
      tcnt      <= '0;
    end else begin
      eng_rst_n <= (state_nx != ARM);
      eng_start <= (state_nx == LAUNCH);
      if (pop) begin
        eng_a_vec <= mem[rd_ptr][63:32];
        eng_b_vec <= mem[rd_ptr][31:0];
      end
      if (state == LAUNCH)   tcnt <= '0;
      else if (state == RUN) tcnt <= tcnt + 1'b1;
    end
  end

  // Done takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      jobs_done   <= '0;
    end else begin
      if (state == RUN) begin
        if (eng_done) begin
          res_data    <= eng_result;
          res_timeout <= 1'b0;
          res_valid   <= 1'b1;
        end else if (tcnt == TMAX) begin
          res_data    <= '0;
          res_timeout <= 1'b1;
          res_valid   <= 1'b1;
        end
      end
      if (state == RESULT && res_ready) begin
        res_valid <= 1'b0;
        jobs_done <= jobs_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cosine_job_ctrl.sv
// Scoreboard bench for cosine_job_ctrl with a behavioural engine model.
// Directed jobs; expected results queued at push, checked at handshake.
`timescale 1ns/1ps
module tb_cosine_job_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_a, job_b;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_timeout;
  logic        eng_rst_n, eng_start;
  logic [31:0] eng_a_vec, eng_b_vec;
  logic        eng_done = 1'b0;
  logic [15:0] eng_result = '0;
  logic        busy;
  logic [7:0]  jobs_done;

  cosine_job_ctrl #(.DEPTH(4), .TIMEOUT(40)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_timeout(res_timeout),
    .eng_rst_n(eng_rst_n), .eng_start(eng_start),
    .eng_a_vec(eng_a_vec), .eng_b_vec(eng_b_vec),
    .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; logic to; } exp_t;
  typedef struct { int d; logic [15:0] r; } eng_t;

  exp_t sb[$];
  eng_t eng_q[$];
  eng_t ce;
  int   rem = 0;
  bit   e_run = 0;

  int errors = 0, checks = 0;
  int exp_done = 0;
  bit mon_en = 0;
  int lo_run = 0, st_run = 0, n_rst = 0, n_start = 0;
  int last_wait;
  logic last_rst;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Engine: done becomes visible in RUN cycle d; d=0 never finishes.
  always @(posedge clk or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      eng_done <= 1'b0;
      e_run    <= 1'b0;
    end else if (eng_start) begin
      if (eng_q.size() > 0) ce = eng_q.pop_front();
      else begin ce.d = 0; ce.r = '0; end
      eng_result <= ce.r;
      e_run      <= (ce.d != 0);
      if (ce.d == 1) eng_done <= 1'b1;
      else           rem <= ce.d - 1;
    end else if (e_run && !eng_done) begin
      if (rem == 1) eng_done <= 1'b1;
      else          rem <= rem - 1;
    end
  end

  always @(negedge clk) begin
    #1;
    if (reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {16'h0, res_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", {16'h0, res_data}, {16'h0, e.data});
        chk("res_timeout", {31'h0, res_timeout}, {31'h0, e.to});
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (!eng_rst_n) lo_run++;
      else if (lo_run != 0) begin
        chk("rst_pulse_width", lo_run, 1);
        n_rst++;
        lo_run = 0;
      end
      if (eng_start) st_run++;
      else if (st_run != 0) begin
        chk("start_pulse_width", st_run, 1);
        n_start++;
        st_run = 0;
      end
    end
  end

  task automatic push_job(input logic [31:0] a, input logic [31:0] b,
                          input int d, input logic [15:0] r,
                          input logic [15:0] ed, input logic et);
    int n;
    job_valid = 1'b1;
    job_a = a;
    job_b = b;
    n = 0;
    while (!job_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    last_rst  = eng_rst_n;
    if (!job_ready) chk("push_accept", {31'h0, job_ready}, 32'h1);
    @(posedge clk);
    sb.push_back('{ed, et});
    eng_q.push_back('{d, r});
    exp_done++;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (jobs_done != 8'(exp_done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {24'h0, jobs_done}, 32'(8'(exp_done)));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_job_ready"}, {31'h0, job_ready}, 32'h1);
    chk({nm, "_res_valid"}, {31'h0, res_valid}, 32'h0);
    chk({nm, "_res_data"}, {16'h0, res_data}, 32'h0);
    chk({nm, "_res_timeout"}, {31'h0, res_timeout}, 32'h0);
    chk({nm, "_eng_rst_n"}, {31'h0, eng_rst_n}, 32'h0);
    chk({nm, "_eng_start"}, {31'h0, eng_start}, 32'h0);
    chk({nm, "_eng_a_vec"}, eng_a_vec, 32'h0);
    chk({nm, "_eng_b_vec"}, eng_b_vec, 32'h0);
    chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
    chk({nm, "_jobs_done"}, {24'h0, jobs_done}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, miss, eng_seen;
    logic [15:0] held;
    reset = 1'b0;
    job_valid = 1'b0;
    job_a = '0;
    job_b = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Single job, nominal latency
    res_ready = 1'b1;
    push_job(32'h04030201, 32'h08070605, 26, 16'h0007, 16'h0007, 1'b0);
    wait_done("t1_jobs_done");
    chk("t1_busy_after", {31'h0, busy}, 32'h0);
    chk("t1_eng_a_held", eng_a_vec, 32'h04030201);
    chk("t1_eng_b_held", eng_b_vec, 32'h08070605);

    // Stalled engine, FIFO fills to DEPTH behind the in-flight job
    push_job(32'h11111111, 32'h22222222, 0, 16'h0, 16'h0000, 1'b1);
    for (int i = 2; i <= 5; i++)
      push_job(32'(i), 32'(i * 3), 5, 16'(16'h0010 + i),
               16'(16'h0010 + i), 1'b0);
    chk("t2_ready_when_full", {31'h0, job_ready}, 32'h0);
    chk("t2_busy", {31'h0, busy}, 32'h1);
    push_job(32'h00000006, 32'h00000012, 5, 16'h0016, 16'h0016, 1'b0);
    chk("t2_6th_waited", {31'h0, last_wait > 20}, 32'h1);
    chk("t2_6th_after_pop", {31'h0, last_rst}, 32'h0);
    wait_done("t2_jobs_done");

    // Timeout latency then a normal job
    push_job(32'hAAAA0000, 32'h0000BBBB, 0, 16'h0, 16'h0000, 1'b1);
    n = 0;
    while (!eng_start && n < 50) begin @(negedge clk); n++; end
    chk("t3_launch_seen", {31'h0, eng_start}, 32'h1);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    chk("t3_timeout_latency", n, 41);
    push_job(32'h01010101, 32'h02020202, 10, 16'h0123, 16'h0123, 1'b0);
    wait_done("t3_jobs_done");

    // Back-pressure on the result port
    res_ready = 1'b0;
    push_job(32'h0A, 32'h0B, 3, 16'h0AAA, 16'h0AAA, 1'b0);
    push_job(32'h0C, 32'h0D, 3, 16'h0BBB, 16'h0BBB, 1'b0);
    push_job(32'h0E, 32'h0F, 3, 16'h0CCC, 16'h0CCC, 1'b0);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    chk("t4_res_valid_seen", {31'h0, res_valid}, 32'h1);
    held = res_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!res_valid || res_data != held || eng_start) bad++;
    end
    chk("t4_hold_stable", bad, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_dropped", {31'h0, res_valid}, 32'h0);
    chk("t4_idle_rst_high", {31'h0, eng_rst_n}, 32'h1);
    @(negedge clk);
    chk("t4_rearm", {31'h0, eng_rst_n}, 32'h0);
    wait_done("t4_jobs_done");

    // Done near and at the timeout boundary
    push_job(32'h41, 32'h42, 41, 16'h0777, 16'h0000, 1'b1);
    push_job(32'h39, 32'h3A, 39, 16'h0555, 16'h0555, 1'b0);
    push_job(32'h40, 32'h4A, 40, 16'h0666, 16'h0666, 1'b0);
    wait_done("t5_jobs_done");
    repeat (2) @(negedge clk);
    chk("start_pulse_count", n_start, exp_done);
    chk("rst_pulse_count", n_rst, exp_done);

    // Asynchronous reset in RUN with jobs queued
    mon_en = 1'b0;
    push_job(32'h51, 32'h52, 0, 16'h0, 16'h0, 1'b1);
    push_job(32'h53, 32'h54, 5, 16'h0101, 16'h0101, 1'b0);
    push_job(32'h55, 32'h56, 5, 16'h0202, 16'h0202, 1'b0);
    push_job(32'h57, 32'h58, 5, 16'h0303, 16'h0303, 1'b0);
    repeat (6) @(negedge clk);
    chk("t6_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk_reset_vals("t6");
    sb.delete();
    eng_q.delete();
    exp_done = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    miss = 0;
    eng_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (res_valid) bad++;
      if (!job_ready || busy || jobs_done != 8'h0) miss++;
      if (eng_start || !eng_rst_n) eng_seen++;
    end
    chk("t6_no_spurious_valid", bad, 0);
    chk("t6_empty_after", miss, 0);
    chk("t6_no_launch", eng_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
